uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It adds configurable data width, optional parity, and 1 or 2 stop bits. It also adds an input synchroniser, start-bit glitch rejection, and framing/parity error reporting. A valid/ready output register with overrun detection sits between the serial line and the consuming logic (FIFO or register bank).

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity helper
// Purpose: definitions shared by the parametrised UART receiver and the
//          future parametrised transmitter.
// Contents: uart_state_t  receiver/transmitter state encoding
//           uart_parity() parity bit a transmitter appends to a payload
package uart_pkg;

   localparam int UART_MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   // Even parity is the XOR of the payload, odd parity its inverse.
   // Narrower payloads are zero-extended by the caller; zeros do not
   // change the result.
   function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser, resets to the idle-high level
// Purpose: brings the asynchronous serial line into the clk domain.
// Ports:   clk  system clock
//          rst  asynchronous active-high reset (both flops go to 1)
//          d    asynchronous input
//          q    synchronised output, two clk cycles behind d
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output register
// Purpose: receives start + DATA_BITS (LSB first) + optional parity + 1 or 2
//          stop bits, rejects short start glitches, reports framing and
//          parity errors and flags frames lost to a full output register.
// Ports:   clk        system clock, rising edge
//          rst        asynchronous active-high reset
//          rx         serial line, asynchronous, idle high
//          data_out   received payload, stable while out_valid
//          out_valid  a frame is held in the output register
//          out_ready  consumer takes the frame when out_valid & out_ready
//          frame_err  held frame had a low stop sample (qualified by out_valid)
//          parity_err held frame had a parity mismatch (qualified by out_valid)
//          overrun    one-cycle pulse when a completed frame is dropped
//          busy       receiver is not idle
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   uart_state_t          state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 stop_low;
   logic                 rx_s;

   logic [UART_MAX_DATA_BITS-1:0] data_ext;
   logic                          cnt_zero;
   logic                          frame_err_next;
   logic                          parity_err_next;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_comb begin
      data_ext = '0;
      data_ext[DATA_BITS-1:0] = shreg;
   end

   assign cnt_zero        = (cnt == '0);
   // stop_low carries the first stop sample of a two-stop frame
   assign frame_err_next  = stop_low | ~rx_s;
   assign parity_err_next = (PARITY_EN != 0) &&
                            (uart_parity(data_ext, (PARITY_ODD != 0)) != par_bit);
   assign busy            = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         stop_low   <= 1'b0;
         data_out   <= '0;
         out_valid  <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= HALF_M1;
                  state <= START;
               end
            end

            START: begin
               if (cnt_zero) begin
                  // still low at mid start bit: a real frame, else a glitch
                  if (!rx_s) begin
                     cnt     <= BIT_M1;
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            DATA: begin
               if (cnt_zero) begin
                  shreg[bit_idx] <= rx_s;
                  cnt            <= BIT_M1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx  <= '0;
                     stop_low <= 1'b0;
                     state    <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            PARITY: begin
               if (cnt_zero) begin
                  par_bit <= rx_s;
                  cnt     <= BIT_M1;
                  state   <= STOP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            STOP: begin
               if (cnt_zero) begin
                  if (STOP_BITS == 2 && bit_idx == '0) begin
                     // first of two stop bits: remember it and wait one more bit
                     stop_low <= ~rx_s;
                     bit_idx  <= IW'(1);
                     cnt      <= BIT_M1;
                  end else begin
                     // completion; a frame being taken this cycle frees the slot
                     if (!out_valid || out_ready) begin
                        data_out   <= shreg;
                        frame_err  <= frame_err_next;
                        parity_err <= parity_err_next;
                        out_valid  <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     // a low line must return high before another start is seen
                     state <= rx_s ? IDLE : BREAK;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param
module tb_uart_rx_param;

   typedef struct {
      int         dut;
      int         done;
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] dout [2];
   logic       val  [2];
   logic       ferr [2];
   logic       perr [2];
   logic       ovr  [2];
   logic       bsy  [2];
   logic       rdy  [2];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit abort = 1'b0;

   frame_t     pend [$];
   int         last_done [2];
   logic       exp_valid [2];
   logic [7:0] exp_data  [2];
   logic       exp_ferr  [2];
   logic       exp_perr  [2];
   logic       exp_ovr   [2];

   logic [7:0] cap_data [2];
   logic       cap_ferr [2];
   logic       cap_perr [2];
   int         cap_cnt  [2];
   int         ovr_seen [2];
   logic       prev_val [2];
   logic       prev_rdy [2];

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(10)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .data_out(dout[0]), .out_valid(val[0]),
      .out_ready(rdy[0]), .frame_err(ferr[0]), .parity_err(perr[0]),
      .overrun(ovr[0]), .busy(bsy[0])
   );

   uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .data_out(dout[1]), .out_valid(val[1]),
      .out_ready(rdy[1]), .frame_err(ferr[1]), .parity_err(perr[1]),
      .overrun(ovr[1]), .busy(bsy[1])
   );

   function automatic int cpb_of(input int d);
      return (d == 0) ? 10 : 8;
   endfunction

   function automatic bit pe_of(input int d);
      return (d == 1);
   endfunction

   function automatic int sb_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int d, input logic v);
      if (d == 0) rx_a = v;
      else        rx_b = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame and registers what it must produce, and when.
   task automatic send(input int d, input logic [7:0] data, input logic pbit,
                       input logic stop_lvl);
      logic   bits [16];
      int     nb;
      frame_t f;
      nb = 0;
      bits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin bits[nb] = data[i]; nb++; end
      if (pe_of(d)) begin bits[nb] = pbit; nb++; end
      for (int s = 0; s < sb_of(d); s++) begin bits[nb] = stop_lvl; nb++; end
      f.dut  = d;
      f.data = data;
      f.ferr = ~stop_lvl;
      f.perr = pe_of(d) ? ((^data) ^ pbit) : 1'b0;
      // mid last stop bit after the fall, plus the synchroniser delay
      f.done = cyc + 3 + nb * cpb_of(d) - cpb_of(d) / 2;
      last_done[d] = f.done;
      pend.push_back(f);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < cpb_of(d); c++) begin
            drive(d, abort ? 1'b1 : bits[b]);
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Output-register model: frames arrive at their computed completion cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            exp_data[d]  = 8'h00;
            exp_ferr[d]  = 1'b0;
            exp_perr[d]  = 1'b0;
            exp_ovr[d]   = 1'b0;
         end
         pend.delete();
      end else begin
         cyc = cyc + 1;
         for (int d = 0; d < 2; d++) begin
            bit     hs;
            bit     hit;
            frame_t f;
            hs  = exp_valid[d] && rdy[d];
            hit = 1'b0;
            exp_ovr[d] = 1'b0;
            foreach (pend[i]) begin
               if (pend[i].dut == d && pend[i].done == cyc) begin
                  hit = 1'b1;
                  f   = pend[i];
               end
            end
            if (hit) begin
               if (!exp_valid[d] || hs) begin
                  exp_valid[d] = 1'b1;
                  exp_data[d]  = f.data;
                  exp_ferr[d]  = f.ferr;
                  exp_perr[d]  = f.perr;
               end else begin
                  exp_ovr[d] = 1'b1;
               end
            end else if (hs) begin
               exp_valid[d] = 1'b0;
            end
         end
         for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].done <= cyc) pend.delete(i);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.out_valid", d), 32'(val[d]), 32'(exp_valid[d]));
            chk($sformatf("dut%0d.overrun", d), 32'(ovr[d]), 32'(exp_ovr[d]));
            if (exp_valid[d]) begin
               chk($sformatf("dut%0d.data_out", d), 32'(dout[d]), 32'(exp_data[d]));
               chk($sformatf("dut%0d.frame_err", d), 32'(ferr[d]), 32'(exp_ferr[d]));
               chk($sformatf("dut%0d.parity_err", d), 32'(perr[d]), 32'(exp_perr[d]));
            end
            if (val[d] && (!prev_val[d] || prev_rdy[d])) begin
               cap_cnt[d]++;
               cap_data[d] = dout[d];
               cap_ferr[d] = ferr[d];
               cap_perr[d] = perr[d];
            end
            if (ovr[d]) ovr_seen[d]++;
            prev_val[d] = val[d];
            prev_rdy[d] = rdy[d];
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int o0;
      for (int d = 0; d < 2; d++) begin
         rdy[d] = 1'b1; cap_cnt[d] = 0; ovr_seen[d] = 0;
         prev_val[d] = 1'b0; prev_rdy[d] = 1'b0; last_done[d] = 0;
         cap_data[d] = 8'h00; cap_ferr[d] = 1'b0; cap_perr[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset.dut%0d.data_out", d), 32'(dout[d]), 0);
         chk($sformatf("reset.dut%0d.out_valid", d), 32'(val[d]), 0);
         chk($sformatf("reset.dut%0d.frame_err", d), 32'(ferr[d]), 0);
         chk($sformatf("reset.dut%0d.parity_err", d), 32'(perr[d]), 0);
         chk($sformatf("reset.dut%0d.overrun", d), 32'(ovr[d]), 0);
         chk($sformatf("reset.dut%0d.busy", d), 32'(bsy[d]), 0);
      end
      rst = 1'b0;
      idle(5);

      // 8N1 0xA5
      n0 = cap_cnt[0];
      send(0, 8'hA5, 1'b0, 1'b1);
      idle(5);
      chk("a5.frames", 32'(cap_cnt[0] - n0), 1);
      chk("a5.data", 32'(cap_data[0]), 32'h A5);
      chk("a5.frame_err", 32'(cap_ferr[0]), 0);
      chk("a5.parity_err", 32'(cap_perr[0]), 0);

      // even parity, two stop bits: 0x07 has odd weight, correct parity bit is 1
      send(1, 8'h07, 1'b0, 1'b1);
      idle(5);
      chk("par_bad.data", 32'(cap_data[1]), 32'h07);
      chk("par_bad.parity_err", 32'(cap_perr[1]), 1);
      send(1, 8'h07, 1'b1, 1'b1);
      idle(5);
      chk("par_ok.parity_err", 32'(cap_perr[1]), 0);
      chk("par_ok.frame_err", 32'(cap_ferr[1]), 0);

      // stop bit low, line held low afterwards
      n0 = cap_cnt[0];
      send(0, 8'h3C, 1'b0, 1'b0);
      idle(30);
      chk("break.busy_low", 32'(bsy[0]), 1);
      rx_a = 1'b1;
      idle(6);
      chk("break.busy_released", 32'(bsy[0]), 0);
      chk("break.frames", 32'(cap_cnt[0] - n0), 1);
      chk("break.data", 32'(cap_data[0]), 32'h3C);
      chk("break.frame_err", 32'(cap_ferr[0]), 1);

      // start glitch of 3 cycles
      n0 = cap_cnt[0];
      rx_a = 1'b0;
      idle(3);
      chk("glitch.busy_mid", 32'(bsy[0]), 1);
      rx_a = 1'b1;
      idle(15);
      chk("glitch.busy_after", 32'(bsy[0]), 0);
      chk("glitch.frames", 32'(cap_cnt[0] - n0), 0);

      // overrun: consumer stalled
      rdy[0] = 1'b0;
      o0 = ovr_seen[0];
      send(0, 8'h11, 1'b0, 1'b1);
      idle(3);
      send(0, 8'h22, 1'b0, 1'b1);
      idle(3);
      chk("ovr.pulses", 32'(ovr_seen[0] - o0), 1);
      chk("ovr.held_data", 32'(dout[0]), 32'h11);
      chk("ovr.held_valid", 32'(val[0]), 1);
      rdy[0] = 1'b1;
      idle(2);
      rdy[0] = 1'b0;

      // consumer takes the old frame on the completion cycle of the new one
      send(0, 8'h11, 1'b0, 1'b1);
      idle(3);
      o0 = ovr_seen[0];
      fork
         send(0, 8'h22, 1'b0, 1'b1);
         begin
            #2;
            for (int i = 0; i < 400 && cyc < last_done[0] - 1; i++) begin
               @(posedge clk);
               #1;
            end
            rdy[0] = 1'b1;
         end
      join
      idle(3);
      chk("swap.pulses", 32'(ovr_seen[0] - o0), 0);
      chk("swap.data", 32'(cap_data[0]), 32'h22);
      chk("swap.drained", 32'(val[0]), 0);

      // reset during data bit 4 of 0x5A, with dut1 holding a frame
      rdy[1] = 1'b0;
      send(1, 8'h07, 1'b1, 1'b1);
      idle(3);
      chk("rst.pre_b_valid", 32'(val[1]), 1);
      fork
         send(0, 8'h5A, 1'b0, 1'b1);
         begin
            repeat (55) @(posedge clk);
            #3;
            chk("rst.pre_a_busy", 32'(bsy[0]), 1);
            rst = 1'b1;
            #1;
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("rst.dut%0d.data_out", d), 32'(dout[d]), 0);
               chk($sformatf("rst.dut%0d.out_valid", d), 32'(val[d]), 0);
               chk($sformatf("rst.dut%0d.frame_err", d), 32'(ferr[d]), 0);
               chk($sformatf("rst.dut%0d.parity_err", d), 32'(perr[d]), 0);
               chk($sformatf("rst.dut%0d.busy", d), 32'(bsy[d]), 0);
            end
            abort = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
         end
      join
      abort = 1'b0;
      rdy[1] = 1'b1;
      idle(5);

      n0 = cap_cnt[0];
      send(0, 8'h5A, 1'b0, 1'b1);
      idle(5);
      chk("post_rst.frames", 32'(cap_cnt[0] - n0), 1);
      chk("post_rst.data", 32'(cap_data[0]), 32'h5A);
      chk("post_rst.frame_err", 32'(cap_ferr[0]), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
